rho_pi_lane_serial: RTL
=======================

# rho_pi_lane_serial

Lane-serial Keccak rho+pi step unit, parametrised over lane width W = 2^L to cover Keccak-f[25·W] for W = 8..64. It accepts the 25 lanes of a state one per handshake, rotates each lane by its rho offset reduced mod W, and stores it at its pi destination in an internal 25×W buffer. It then streams the permuted state out one lane per handshake. It sits between a lane-serial theta stage and the chi/iota stage in the area-optimised permutation datapath.

## Interface
- L, default 6: log2 of lane width, legal 3..6; W = 2^L.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  bit0 = rho enable, bit1 = pi enable; sampled with input lane 0.
- s_valid  in  1  input lane valid.
- s_ready  out  1  input lane ready.
- s_data  in  W  input lane.
- s_last  in  1  marks the lane the source believes is lane 24.
- m_valid  out  1  output lane valid.
- m_ready  in  1  output lane accepted.
- m_data  out  W  output lane.
- m_last  out  1  high with output lane 24.
- err  out  1  one-cycle pulse on a framing error.

## Operation
- Lane index i = 5y + x. Input and output both run i = 0..24 in order. Output ordering is over destination coordinates.
- Rho offsets r[y][x] before reduction:
  - y0: 0, 1, 62, 28, 27
  - y1: 36, 44, 6, 55, 20
  - y2: 3, 10, 43, 25, 39
  - y3: 41, 45, 15, 21, 8
  - y4: 18, 2, 61, 56, 14
- Effective offset = r mod W (low L bits). Rotation is left: out[z] = in[(z − r) mod W].
- Pi: source lane (x, y) is written to destination (x' = y, y' = (2x + 3y) mod 5).
- Mode is latched when input lane 0 is accepted and held for the whole state, including drain.
  - mode bit0 = 0: offset forced to 0.
  - mode bit1 = 0: destination = source.
  - mode = 0: pass-through.
- FSM has two states:
  - LOAD: s_ready = 1, m_valid = 0. Each handshake writes the processed lane to the buffer and increments in_cnt (0..24). The handshake at in_cnt = 24 clears in_cnt and moves to DRAIN.
  - DRAIN: s_ready = 0, m_valid = 1, m_data = buf[out_cnt], m_last = (out_cnt == 24). Each handshake increments out_cnt. The handshake at out_cnt = 24 clears out_cnt and moves to LOAD.
- Framing check: an accepted lane with s_last ≠ (in_cnt == 24) pulses err high for one cycle.
  - The lane is still stored. in_cnt, not s_last, governs framing. No resynchronisation.
- Rotation and pi-address logic is generated from L. No per-width hand tables beyond the 25 base offsets.

## Timing
- Reset (async assert, sync deassert by the system) sets:
  - state = LOAD, in_cnt = out_cnt = 0, latched mode = 0, buffer = 0, err = 0.
  - Hence s_ready = 1, m_valid = 0, m_last = 0, m_data = 0.
- s_ready and m_valid are decoded from state only. They never depend combinationally on s_valid or m_ready.
- Latency: the first output lane is valid the cycle after the handshake of input lane 24.
  - Unstalled throughput: 50 cycles per state (25 load + 25 drain). No load/drain overlap.
- Under m_ready = 0, m_data and m_last hold stable. s_valid during DRAIN is ignored and produces no err.
- Return to LOAD: s_ready is 1 in the cycle after the output lane 24 handshake.
- Reset mid-LOAD or mid-DRAIN discards the partial state. The next accepted lane is lane 0.
- err is registered: it is high in the cycle after the offending handshake.

## Test plan
- W=64, mode=3, every input lane = 0x1 → output lane 0 = 0x1, lane 1 = 0x0000100000000000 (source (1,1), r=44), lane 5 = 0x0000000010000000 (source (3,0), r=28).
- W=64, mode=2 (pi only), input lane i = i → output lane 1 = 6, lane 5 = 3, lane 24 = 21 (source (1,4)), all unrotated.
- L=3 (W=8), mode=1 (rho only), every lane = 0x01 → lane 2 = 0x40 (62 mod 8 = 6), lane 1 = 0x02, lane 0 = 0x01.
- Random m_ready backpressure with a random s_valid gap pattern, 10 back-to-back states → outputs match the golden model. m_data is stable while stalled. m_last coincides only with lane 24.
- s_last on lane 10 and missing on lane 24 → err pulses twice, output is still correct. Drive rst_n low at in_cnt = 12 → s_ready = 1, m_valid = 0 immediately. The next 25 lanes form a clean state.

Source files
------------

// File: rtl/rho_pi_lane_serial.sv
// Lane-serial Keccak rho+pi unit: loads 25 lanes, rotates each by its rho offset,
// stores it at its pi destination, then streams the permuted state out in lane order.
module rho_pi_lane_serial #(
    parameter int unsigned L = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [(2**L)-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [(2**L)-1:0] m_data,
    output logic              m_last,
    output logic              err
);

    localparam int unsigned W      = 2 ** L;
    localparam int unsigned NLANES = 25;
    localparam int unsigned CW     = 5;
    localparam logic [CW-1:0] LAST_LANE = CW'(24);

    localparam logic [0:0] LOAD  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    // Base rho offsets indexed by lane i = 5y + x, before reduction mod W.
    function automatic logic [5:0] rho_base(input logic [CW-1:0] i);
        case (i)
            5'd0:  rho_base = 6'd0;   5'd1:  rho_base = 6'd1;   5'd2:  rho_base = 6'd62;
            5'd3:  rho_base = 6'd28;  5'd4:  rho_base = 6'd27;  5'd5:  rho_base = 6'd36;
            5'd6:  rho_base = 6'd44;  5'd7:  rho_base = 6'd6;   5'd8:  rho_base = 6'd55;
            5'd9:  rho_base = 6'd20;  5'd10: rho_base = 6'd3;   5'd11: rho_base = 6'd10;
            5'd12: rho_base = 6'd43;  5'd13: rho_base = 6'd25;  5'd14: rho_base = 6'd39;
            5'd15: rho_base = 6'd41;  5'd16: rho_base = 6'd45;  5'd17: rho_base = 6'd15;
            5'd18: rho_base = 6'd21;  5'd19: rho_base = 6'd8;   5'd20: rho_base = 6'd18;
            5'd21: rho_base = 6'd2;   5'd22: rho_base = 6'd61;  5'd23: rho_base = 6'd56;
            5'd24: rho_base = 6'd14;
            default: rho_base = 6'd0;
        endcase
    endfunction

    // Pi maps source (x, y) to destination (y, (2x + 3y) mod 5).
    function automatic logic [CW-1:0] pi_dst(input logic [CW-1:0] i);
        int x;
        int y;
        x = int'(i) % 5;
        y = int'(i) / 5;
        pi_dst = CW'(5 * ((2 * x + 3 * y) % 5) + y);
    endfunction

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] in_cnt_q, out_cnt_q;
    logic [1:0]    mode_q;
    logic          err_q;
    logic [W-1:0]  lane_buf [NLANES];

    logic          s_hs, m_hs;
    logic [1:0]    mode_eff;
    logic [5:0]    rho_full;
    logic [L-1:0]  rot_amt;
    logic [CW-1:0] dst;
    logic [W-1:0]  lane_rot;

    assign s_ready = (state_q == LOAD);
    assign m_valid = (state_q == DRAIN);
    assign m_last  = m_valid && (out_cnt_q == LAST_LANE);
    assign m_data  = m_valid ? lane_buf[out_cnt_q] : '0;
    assign err     = err_q;

    assign s_hs = s_valid && s_ready;
    assign m_hs = m_valid && m_ready;

    // Lane 0 uses the live mode input; later lanes use the value latched with lane 0.
    always_comb begin
        mode_eff = (in_cnt_q == '0) ? mode : mode_q;
        rho_full = rho_base(in_cnt_q);
        rot_amt  = mode_eff[0] ? rho_full[L-1:0] : '0;
        dst      = mode_eff[1] ? pi_dst(in_cnt_q) : in_cnt_q;
        lane_rot = '0;
        for (int z = 0; z < int'(W); z++) begin
            lane_rot[z] = s_data[L'(z - int'(rot_amt))];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (s_valid && in_cnt_q == LAST_LANE) state_d = DRAIN;
            DRAIN:   if (m_ready && out_cnt_q == LAST_LANE) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Counters, latched mode and the registered framing-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            mode_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= s_hs && (s_last != (in_cnt_q == LAST_LANE));
            if (s_hs) begin
                in_cnt_q <= (in_cnt_q == LAST_LANE) ? '0 : in_cnt_q + CW'(1);
                if (in_cnt_q == '0) mode_q <= mode;
            end
            if (m_hs) begin
                out_cnt_q <= (out_cnt_q == LAST_LANE) ? '0 : out_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NLANES); k++) lane_buf[k] <= '0;
        end else if (s_hs) begin
            lane_buf[dst] <= lane_rot;
        end
    end

endmodule
